// File: rtl/fp32_mul_gather.sv
// ============================================================================
// Module      : fp32_mul_gather
// Description : Gathers the fp32_mul product stream into 4-lane 128-bit
//               vectors, with credit-based flow control toward the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_mul_gather #(
    parameter int DEPTH = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         issue_in,
    output logic         credit_out,
    input  logic         valid_in,
    input  logic [31:0]  c_in,
    output logic         valid_out,
    output logic [127:0] data_out,
    input  logic         ready_in,
    output logic         error_out
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_FOUR  = (c_PTR_W + 1)'(4);
    localparam logic [c_PTR_W:0]   c_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_ZERO  = '0;

    logic [31:0]        r_buf [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_stored;
    logic [c_PTR_W:0]   r_reserved;
    logic               r_error;

    logic               w_issue;
    logic               w_write;
    logic               w_pop;
    logic               w_bad_issue;
    logic               w_orphan;
    logic [c_PTR_W:0]   w_stored_next;
    logic [c_PTR_W:0]   w_reserved_next;
    logic [127:0]       w_vec;

    assign credit_out = (r_reserved < c_DEPTH);
    assign valid_out  = (r_stored >= c_FOUR);
    assign error_out  = r_error;

    assign w_issue     = issue_in & credit_out;
    assign w_write     = valid_in & (r_reserved > r_stored);
    assign w_pop       = valid_out & ready_in;
    assign w_bad_issue = issue_in & ~credit_out;
    assign w_orphan    = valid_in & (r_reserved == r_stored);

    // Deltas are summed so simultaneous issue/write/pop compose naturally.
    always_comb begin
        w_stored_next   = r_stored + (w_write ? c_ONE : c_ZERO) - (w_pop ? c_FOUR : c_ZERO);
        w_reserved_next = r_reserved + (w_issue ? c_ONE : c_ZERO) - (w_pop ? c_FOUR : c_ZERO);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_stored   <= '0;
            r_reserved <= '0;
            r_error    <= 1'b0;
        end else begin
            r_stored   <= w_stored_next;
            r_reserved <= w_reserved_next;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(4);
            end
            if (w_bad_issue || w_orphan) begin
                r_error <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers and counters define validity.
    always_ff @(posedge clk_in) begin
        if (w_write) begin
            r_buf[r_wr_ptr] <= c_in;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [c_PTR_W-1:0] w_idx;
            assign w_idx = r_rd_ptr + c_PTR_W'(gi);
            assign w_vec[32*gi +: 32] = r_buf[w_idx];
        end
    endgenerate

    assign data_out = valid_out ? w_vec : 128'd0;

endmodule

`default_nettype wire

// File: doc/fp32_mul_gather.md
# fp32_mul_gather

Downstream collector for the fp32 multiplier. It captures the scalar product stream from `fp32_mul`, which has no backpressure, into a buffer. It packs four consecutive products into one 128-bit vector word and presents it on a ready/valid output. A credit signal to the issuing sequencer bounds the number of in-flight products, so a result that has already left the multiplier is never dropped.

## Interface

Parameters:
- `DEPTH`, default 16: buffer capacity in 32-bit elements. Must be a power of two, a multiple of 4, and ≥ 8.

Ports:
- `clk_in` input 1: single system clock; all state updates on rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `issue_in` input 1: the sequencer launched one operation into `fp32_mul` this cycle.
- `credit_out` output 1: high when an issue is permitted this cycle.
- `valid_in` input 1: multiplier `valid_out`.
- `c_in` input 32: multiplier `c_out`; sampled only when `valid_in` is high.
- `valid_out` output 1: a 4-element vector is available.
- `data_out` output 128: the vector. Lane k is in `[32k+31:32k]`, and lane 0 is the oldest product.
- `ready_in` input 1: the consumer accepts the vector this cycle.
- `error_out` output 1: sticky protocol-violation flag.

## Operation

State:
- Circular element buffer `DEPTH`×32, with write pointer and read pointer of log2(`DEPTH`) bits each; both wrap modulo `DEPTH`.
- `stored` counter, 0..`DEPTH`: elements currently in the buffer.
- `reserved` counter, 0..`DEPTH`: `stored` plus products in flight. In-flight count is `reserved` − `stored`, always ≥ 0.

Outputs:
- `credit_out` = (`reserved` < `DEPTH`). Combinational from the registered counter.
- `valid_out` = (`stored` ≥ 4). Combinational from the registered counter.
- `data_out` = buffer entries at read pointer +0..+3, modulo `DEPTH` (show-ahead read). Forced to 0 whenever `valid_out` is low.

Per-cycle events:
- Issue: `issue_in` && `credit_out`. `reserved` += 1.
- Write: `valid_in` && (`reserved` > `stored`). Store `c_in` at the write pointer, advance the write pointer, `stored` += 1.
- Pop: `valid_out` && `ready_in`. Read pointer += 4, `stored` −= 4, `reserved` −= 4.
- Issue, write and pop may occur in the same cycle. The net counter update is the sum of the individual deltas; e.g. issue + write + pop gives `reserved` −3 and `stored` −3.
- A pop and a write in the same cycle never conflict. The write targets a slot outside the 4 popped slots, because `stored` ≤ `DEPTH`.

Errors (sticky `error_out` = 1, cleared only by reset):
- `issue_in` while `credit_out` is low. The issue is ignored and `reserved` is unchanged.
- `valid_in` while `reserved` == `stored` (a product with no outstanding issue). The product is discarded and the buffer is unchanged.
- Normal operation continues after an error.

Arithmetic rules:
- Counters are log2(`DEPTH`)+1 bits wide.
- No saturation logic is required. The credit and error rules keep both counters in range.

## Timing

- Reset values:
  - `valid_out` = 0, `data_out` = 0, `error_out` = 0, `credit_out` = 1.
  - Pointers and counters = 0.
  - Buffer contents are not reset.
- Reset mid-operation discards all buffered and in-flight accounting. The sequencer must also drop in-flight multiplier results (e.g. by gating the multiplier's `valid_in`) for 6 cycles after reset. Otherwise those results raise `error_out`.
- Write latency: a product sampled at edge N is counted in `stored` after edge N. If it completes a group of 4, `valid_out` is high in cycle N+1.
- Credit latency:
  - A pop at edge N raises `credit_out` in cycle N+1 if `reserved` was `DEPTH`.
  - An issue at edge N that fills the last slot lowers `credit_out` in cycle N+1.
- Throughput:
  - Sustains one product per cycle indefinitely when `ready_in` is high at least every 4th cycle.
  - Pops at most one vector per cycle.

## Test plan

- Reset, then 4 issues; one cycle later, 4 products 0x3F800000, 0x40000000, 0x40400000, 0x40800000 arrive. → `valid_out` rises the cycle after the 4th write. `data_out` = {0x40800000, 0x40400000, 0x40000000, 0x3F800000}. A pop with `ready_in` = 1 returns `valid_out` to 0.
- `DEPTH` = 16, `ready_in` held 0, issue every cycle. → `credit_out` falls after the 16th issue. 16 products are stored, `valid_out` stays high and `error_out` stays 0. Raise `ready_in` for one cycle → `credit_out` is 1 the next cycle for exactly 4 more issues.
- Continuous issue of 64 products with a random `ready_in` pattern, ≥25% high. → 16 vectors emitted in order, no loss, pointers wrap at least 3 times, `error_out` stays 0.
- Same-cycle issue, write and pop with `stored` = 4 and `reserved` = 6. → next cycle `stored` = 1, `reserved` = 3, and the written element is lane 0 of the following vector.
- `valid_in` pulse with no outstanding issue, and `issue_in` while `credit_out` = 0. → `error_out` = 1 from the next cycle, counters unchanged. It stays set until `rst_in`, which clears it along with `valid_out` and sets `credit_out` = 1.
